// File: rtl/tmds_tx_serializer.sv
// DVI/HDMI transmitter in the bit-clock domain: pixel clock-enable, three TMDS
// 8b/10b encoders and LSB-first lane serialisers with SDR or DDR bit pairs.
module tmds_tx_serializer #(
  parameter int unsigned C_DDR        = 0,
  parameter int unsigned C_CLOCK_LANE = 1
) (
  input  logic       pixclk_x10,
  input  logic       reset,
  output logic       pixel_ce,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic       vga_blank,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  output logic [3:0] tmds_d0,
  output logic [3:0] tmds_d1
);

  localparam int unsigned RATIO   = (C_DDR != 0) ? 5 : 10;
  localparam int unsigned STEP    = (C_DDR != 0) ? 2 : 1;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned WORD_W  = 10;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned NLANE   = 3;

  localparam logic [PHASE_W-1:0]      PHASE_LAST  = PHASE_W'(RATIO - 1);
  localparam logic [PHASE_W-1:0]      PHASE_PRE   = PHASE_W'(RATIO - 2);
  localparam logic [WORD_W-1:0]       CLK_PATTERN = 10'b0000011111;
  localparam logic signed [CNT_W-1:0] CNT_TWO     = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  // Returns {next disparity, encoded word} for one lane.
  function automatic logic [CNT_W+WORD_W-1:0] tmds_encode(
    input logic                    blank,
    input logic [1:0]              cd,
    input logic [7:0]              d,
    input logic signed [CNT_W-1:0] cnt
  );
    logic [8:0]              qm;
    logic [3:0]              n1_d;
    logic [3:0]              n1_q;
    logic [3:0]              n0_q;
    logic                    use_xnor;
    logic signed [CNT_W-1:0] diff;
    logic [WORD_W-1:0]       word;
    logic signed [CNT_W-1:0] cnt_n;
    n1_d = '0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + 4'(d[i]);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    n1_q  = '0;
    for (int i = 0; i < 8; i++) n1_q = n1_q + 4'(qm[i]);
    n0_q = 4'd8 - n1_q;
    diff = $signed(CNT_W'(n1_q)) - $signed(CNT_W'(n0_q));
    if (blank) begin
      unique case (cd)
        2'b00:   word = 10'b1101010100;
        2'b01:   word = 10'b0010101011;
        2'b10:   word = 10'b0101010100;
        default: word = 10'b1010101011;
      endcase
      cnt_n = CNT_ZERO;
    end else if ((cnt == CNT_ZERO) || (n1_q == n0_q)) begin
      word  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[CNT_W-1] && (n1_q > n0_q)) || (cnt[CNT_W-1] && (n0_q > n1_q))) begin
      word  = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? CNT_TWO : CNT_ZERO) - diff;
    end else begin
      word  = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? CNT_ZERO : CNT_TWO) + diff;
    end
    return {cnt_n, word};
  endfunction

  logic [PHASE_W-1:0]             phase_q, phase_d;
  logic                           ce_q, ce_d;
  logic [NLANE-1:0][WORD_W-1:0]   enc_q, enc_d;
  logic [NLANE-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [NLANE:0][WORD_W-1:0]     sh_q, sh_d;
  logic [NLANE-1:0][7:0]          pix;
  logic [NLANE-1:0][1:0]          cd;

  assign pix = {vga_r, vga_g, vga_b};
  assign cd  = {2'b00, 2'b00, vga_vsync, vga_hsync};

  // Phase counter, encoders and shifters; the encoders and shift loads act
  // only on the load edge that closes the pixel_ce cycle.
  always_comb begin
    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
    ce_d    = (phase_q == PHASE_PRE);
    enc_d   = enc_q;
    cnt_d   = cnt_q;
    for (int i = 0; i <= NLANE; i++) sh_d[i] = sh_q[i] >> STEP;
    if (ce_q) begin
      for (int i = 0; i < NLANE; i++) begin
        {cnt_d[i], enc_d[i]} = tmds_encode(vga_blank, cd[i], pix[i], cnt_q[i]);
        sh_d[i] = enc_q[i];
      end
      sh_d[NLANE] = (C_CLOCK_LANE != 0) ? CLK_PATTERN : '0;
    end
  end

  always_ff @(posedge pixclk_x10) begin
    if (reset) begin
      phase_q <= '0;
      ce_q    <= 1'b0;
      enc_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      phase_q <= phase_d;
      ce_q    <= ce_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign pixel_ce = ce_q;

  always_comb begin
    for (int i = 0; i <= NLANE; i++) begin
      tmds_d0[i] = sh_q[i][0];
      tmds_d1[i] = (C_DDR != 0) ? sh_q[i][1] : sh_q[i][0];
    end
  end

endmodule

// File: tb/tb_tmds_tx_serializer.sv
// Bench for tmds_tx_serializer: SDR, DDR and no-clock-lane instances, each
// deserialised per word and compared against a bench-side TMDS model.
module tb_tmds_tx_serializer;

  localparam int unsigned NUM_RAND = 24;
  localparam logic [9:0]  CLK_PAT  = 10'b0000011111;

  typedef struct {
    logic       blank;
    logic       vs;
    logic       hs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       has_exp;
    logic [9:0] exp_r;
    logic [9:0] exp_g;
    logic [9:0] exp_b;
  } vec_t;

  typedef logic [3:0][9:0] word4_t;  // {clk, red, green, blue}
  typedef struct packed { logic [9:0] w; int c; } enc_t;

  logic       clk;
  logic       reset;
  logic       s_hs, s_vs, s_blank;
  logic [7:0] s_r, s_g, s_b;
  logic       d_hs, d_vs, d_blank;
  logic [7:0] d_r, d_g, d_b;
  logic       s_ce, n_ce, d_ce;
  logic [3:0] s_d0, s_d1, n_d0, n_d1, d_d0, d_d1;

  tmds_tx_serializer #(.C_DDR(0), .C_CLOCK_LANE(1)) u_sdr (
    .pixclk_x10(clk), .reset(reset), .pixel_ce(s_ce),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_blank(s_blank),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .tmds_d0(s_d0), .tmds_d1(s_d1)
  );

  tmds_tx_serializer #(.C_DDR(0), .C_CLOCK_LANE(0)) u_nocl (
    .pixclk_x10(clk), .reset(reset), .pixel_ce(n_ce),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_blank(s_blank),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .tmds_d0(n_d0), .tmds_d1(n_d1)
  );

  tmds_tx_serializer #(.C_DDR(1), .C_CLOCK_LANE(1)) u_ddr (
    .pixclk_x10(clk), .reset(reset), .pixel_ce(d_ce),
    .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_blank(d_blank),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .tmds_d0(d_d0), .tmds_d1(d_d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t   tbl[$];
  vec_t   dflt;
  word4_t q_s[$];
  word4_t q_d[$];
  word4_t acc_s0, acc_s1, acc_n0, acc_n1, acc_d;
  int     cnt_m[2][3];
  int     cyc, idx_s, idx_d, pops_s, pops_d;
  int     checks, failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic enc_t model_enc(input logic blank, input logic [1:0] cd,
                                     input logic [7:0] d, input int cnt);
    enc_t       res;
    logic [8:0] qm;
    int         ones, n1, n0;
    logic       use_xnor;
    res.w = '0;
    res.c = 0;
    if (blank) begin
      case (cd)
        2'b00:   res.w = 10'b1101010100;
        2'b01:   res.w = 10'b0010101011;
        2'b10:   res.w = 10'b0101010100;
        default: res.w = 10'b1010101011;
      endcase
      return res;
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      res.w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      res.c = cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      res.w = {1'b1, qm[8], ~qm[7:0]};
      res.c = cnt + (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      res.w = {1'b0, qm[8], qm[7:0]};
      res.c = cnt - (qm[8] ? 0 : 2) + n1 - n0;
    end
    return res;
  endfunction

  function automatic vec_t mk(input logic bl, input logic vs, input logic hs,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic he, input logic [9:0] er, input logic [9:0] eg,
                              input logic [9:0] eb);
    vec_t v;
    v.blank = bl; v.vs = vs; v.hs = hs; v.r = r; v.g = g; v.b = b;
    v.has_exp = he; v.exp_r = er; v.exp_g = eg; v.exp_b = eb;
    return v;
  endfunction

  function automatic vec_t vec_at(input int i);
    if (i < tbl.size()) return tbl[i];
    return dflt;
  endfunction

  // Off-load-edge cycles get random inputs, which the encoders must ignore.
  task automatic junk(input int st);
    if (st == 0) begin
      s_blank = 1'($urandom); s_hs = 1'($urandom); s_vs = 1'($urandom);
      s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
    end else begin
      d_blank = 1'($urandom); d_hs = 1'($urandom); d_vs = 1'($urandom);
      d_r = 8'($urandom); d_g = 8'($urandom); d_b = 8'($urandom);
    end
  endtask

  task automatic drive(input int st, input vec_t v);
    word4_t     w;
    enc_t       e;
    logic [7:0] px;
    w    = '0;
    w[3] = CLK_PAT;
    for (int l = 0; l < 3; l++) begin
      px = (l == 0) ? v.b : ((l == 1) ? v.g : v.r);
      e  = model_enc(v.blank, (l == 0) ? {v.vs, v.hs} : 2'b00, px, cnt_m[st][l]);
      cnt_m[st][l] = e.c;
      w[l] = e.w;
    end
    if (v.has_exp) w[2:0] = {v.exp_r, v.exp_g, v.exp_b};
    if (st == 0) begin
      s_blank = v.blank; s_hs = v.hs; s_vs = v.vs; s_r = v.r; s_g = v.g; s_b = v.b;
      q_s.push_back(w);
    end else begin
      d_blank = v.blank; d_hs = v.hs; d_vs = v.vs; d_r = v.r; d_g = v.g; d_b = v.b;
      q_d.push_back(w);
    end
  endtask

  task automatic sb_init();
    word4_t w1;
    w1    = '0;
    w1[3] = CLK_PAT;
    q_s.delete();
    q_d.delete();
    q_s.push_back('0); q_s.push_back(w1);
    q_d.push_back('0); q_d.push_back(w1);
    for (int s = 0; s < 2; s++) for (int l = 0; l < 3; l++) cnt_m[s][l] = 0;
    cyc = 0;
    acc_s0 = '0; acc_s1 = '0; acc_n0 = '0; acc_n1 = '0; acc_d = '0;
  endtask

  task automatic eval();
    int     ps, pd;
    word4_t e;
    cyc++;
    ps = (cyc - 1) % 10;
    pd = (cyc - 1) % 5;
    if (cyc == 1)
      check("reset_outputs", 64'({s_d0, s_d1, n_d0, n_d1, d_d0, d_d1, s_ce, n_ce, d_ce}), 64'(0));
    check("sdr_pixel_ce", 64'(s_ce), 64'(ps == 9));
    check("nocl_pixel_ce", 64'(n_ce), 64'(ps == 9));
    check("ddr_pixel_ce", 64'(d_ce), 64'(pd == 4));
    for (int l = 0; l < 4; l++) begin
      acc_s0[l][ps] = s_d0[l];
      acc_s1[l][ps] = s_d1[l];
      acc_n0[l][ps] = n_d0[l];
      acc_n1[l][ps] = n_d1[l];
      acc_d[l][2*pd]   = d_d0[l];
      acc_d[l][2*pd+1] = d_d1[l];
    end
    if (ps == 9) begin
      if (q_s.size() == 0) begin
        check("sdr_sb_underflow", 64'(0), 64'(1));
      end else begin
        e = q_s.pop_front();
        pops_s++;
        check("sdr_word_d0", 64'(acc_s0), 64'(e));
        check("sdr_word_d1", 64'(acc_s1), 64'(e));
        e[3] = '0;
        check("nocl_word_d0", 64'(acc_n0), 64'(e));
        check("nocl_word_d1", 64'(acc_n1), 64'(e));
      end
      drive(0, vec_at(idx_s));
      idx_s++;
    end else begin
      junk(0);
    end
    if (pd == 4) begin
      if (q_d.size() == 0) begin
        check("ddr_sb_underflow", 64'(0), 64'(1));
      end else begin
        e = q_d.pop_front();
        pops_d++;
        check("ddr_word", 64'(acc_d), 64'(e));
      end
      drive(1, vec_at(idx_d));
      idx_d++;
    end else begin
      junk(1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    sb_init();
    eval();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    idx_s = 0; idx_d = 0; pops_s = 0; pops_d = 0;
    reset = 1'b1;
    junk(0);
    junk(1);
    dflt = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0, '0, '0);
    // Control codes, then the 00-pixel disparity walk from a zero count.
    tbl.push_back(mk(1, 0, 0, 8'h12, 8'h34, 8'h56, 1, 10'h354, 10'h354, 10'h354));
    tbl.push_back(mk(1, 0, 1, 8'hAA, 8'h55, 8'hFF, 1, 10'h354, 10'h354, 10'h0AB));
    tbl.push_back(mk(1, 1, 0, 8'h00, 8'hFF, 8'h0F, 1, 10'h354, 10'h354, 10'h154));
    tbl.push_back(mk(1, 1, 1, 8'h81, 8'h7E, 8'hC3, 1, 10'h354, 10'h354, 10'h2AB));
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h3FF, 10'h3FF, 10'h3FF));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100));
    for (int i = 0; i < NUM_RAND; i++) begin
      tbl.push_back(mk(1'($urandom_range(7, 0) == 0), 1'($urandom), 1'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom), 0, '0, '0, '0));
    end
    tbl.push_back(mk(0, 0, 0, 8'hFF, 8'hF0, 8'h0F, 0, '0, '0, '0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h354, 10'h354, 10'h354));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h3FF, 10'h3FF, 10'h3FF));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'h100, 10'h100, 10'h100));

    do_reset(3);
    for (int i = 0; i < 4000 && pops_s < tbl.size() + 2; i++) cycle();
    check("sdr_table_drained", 64'(pops_s >= tbl.size() + 2), 64'(1));
    check("ddr_table_drained", 64'(pops_d >= tbl.size() + 2), 64'(1));

    // One-cycle reset mid-word while video keeps the disparity non-zero.
    for (int i = 0; i < 20 && ((cyc - 1) % 10) != 4; i++) cycle();
    idx_s = tbl.size();
    idx_d = tbl.size();
    do_reset(1);
    repeat (80) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
